dff_delay_line: RTL and testbench

//   Parametrised D flip-flop delay line: WIDTH-bit data plus a valid flag pass through DEPTH stages.

---
 rtl/dff_pkg.sv | 36 +++
 rtl/dff_delay_line_if.sv | 26 ++
 rtl/dff_stage.sv | 43 ++++
 rtl/dff_delay_line.sv | 69 ++++++
 tb/tb_dff_delay_line.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dff_pkg.sv
// Shared definitions for the programmable DFF delay line: default sizes,
// a clog2 helper and the per-edge action priority (reset > clear > en > hold).
package dff_pkg;

   localparam int unsigned DFF_WIDTH_DEFAULT = 8;
   localparam int unsigned DFF_DEPTH_DEFAULT = 8;

   // Per-edge stage action, ordered by priority.
   typedef enum logic [1:0] {
      ACT_HOLD  = 2'd0,
      ACT_SHIFT = 2'd1,
      ACT_CLEAR = 2'd2,
      ACT_RESET = 2'd3
   } dff_action_e;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      int unsigned v;
      r = 0;
      v = (n > 0) ? n - 1 : 0;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   function automatic dff_action_e dff_action(input logic reset, input logic clear,
                                              input logic en);
      if (reset)      return ACT_RESET;
      else if (clear) return ACT_CLEAR;
      else if (en)    return ACT_SHIFT;
      else            return ACT_HOLD;
   endfunction

endpackage

// File: rtl/dff_delay_line_if.sv
// Control, data and status bundle of the delay line; master drives, slave is the line.
interface dff_delay_line_if
   import dff_pkg::*;
#(
   parameter int unsigned WIDTH = DFF_WIDTH_DEFAULT,
   parameter int unsigned SEL_W = clog2(DFF_DEPTH_DEFAULT)
);
   logic             en;
   logic             clear;
   logic [SEL_W-1:0] delay_sel;
   logic [WIDTH-1:0] d;
   logic             valid_in;
   logic [WIDTH-1:0] q;
   logic             valid_out;
   logic             busy;

   modport master (
      output en, clear, delay_sel, d, valid_in,
      input  q, valid_out, busy
   );

   modport slave (
      input  en, clear, delay_sel, d, valid_in,
      output q, valid_out, busy
   );
endinterface

// File: rtl/dff_stage.sv
// One delay-line stage: a {valid, data} register with sync reset, clear and enable.
module dff_stage
   import dff_pkg::*;
#(
   parameter int unsigned      WIDTH     = DFF_WIDTH_DEFAULT,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             en,
   input  logic [WIDTH-1:0] d_in,
   input  logic             valid_in,
   output logic [WIDTH-1:0] d_out,
   output logic             valid_out
);
   localparam int unsigned      REG_W   = WIDTH + 1;
   localparam logic [REG_W-1:0] CLR_VAL = {1'b0, RESET_VAL};

   dff_action_e      action_c;
   logic [REG_W-1:0] stage_d;
   logic [REG_W-1:0] stage_q;

   // Next-state: flush wins over shift, otherwise hold.
   always_comb begin
      stage_d  = stage_q;
      action_c = dff_action(reset, clear, en);
      unique case (action_c)
         ACT_RESET, ACT_CLEAR: stage_d = CLR_VAL;
         ACT_SHIFT:            stage_d = {valid_in, d_in};
         default:              stage_d = stage_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) stage_q <= CLR_VAL;
      else       stage_q <= stage_d;
   end

   assign d_out     = stage_q[WIDTH-1:0];
   assign valid_out = stage_q[WIDTH];

endmodule

// File: rtl/dff_delay_line.sv
// Programmable 1..DEPTH cycle delay line with stall, flush and a run-time selectable tap.
module dff_delay_line
   import dff_pkg::*;
#(
   parameter int unsigned      WIDTH     = DFF_WIDTH_DEFAULT,
   parameter int unsigned      DEPTH     = DFF_DEPTH_DEFAULT,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int unsigned      SEL_W     = clog2(DEPTH)
) (
   input logic              clk,
   input logic              reset,
   dff_delay_line_if.slave  bus
);
   logic [WIDTH-1:0] stage_data [DEPTH];
   logic [DEPTH-1:0] stage_valid;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_head
         dff_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
            .clk       (clk),
            .reset     (reset),
            .clear     (bus.clear),
            .en        (bus.en),
            .d_in      (bus.d),
            .valid_in  (bus.valid_in),
            .d_out     (stage_data[i]),
            .valid_out (stage_valid[i])
         );
      end else begin : g_body
         dff_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
            .clk       (clk),
            .reset     (reset),
            .clear     (bus.clear),
            .en        (bus.en),
            .d_in      (stage_data[i-1]),
            .valid_in  (stage_valid[i-1]),
            .d_out     (stage_data[i]),
            .valid_out (stage_valid[i])
         );
      end
   end

   logic [SEL_W-1:0] tap_c;
   logic [WIDTH-1:0] q_c;
   logic             valid_out_c;

   // Selects beyond the last stage (non-power-of-2 DEPTH) clamp to the last stage.
   always_comb begin
      tap_c = bus.delay_sel;
      if (32'(bus.delay_sel) >= DEPTH) tap_c = SEL_W'(DEPTH - 1);
   end

   // Compare-based mux so no index can ever fall outside the stage array.
   always_comb begin
      q_c         = stage_data[0];
      valid_out_c = stage_valid[0];
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (tap_c == SEL_W'(i)) begin
            q_c         = stage_data[i];
            valid_out_c = stage_valid[i];
         end
      end
   end

   assign bus.q         = q_c;
   assign bus.valid_out = valid_out_c;
   assign bus.busy      = |stage_valid;

endmodule

// File: tb/tb_dff_delay_line.sv
// Bench for dff_delay_line: DEPTH=8 and DEPTH=6 instances driven with the same stream,
// checked against a beat-history model of the delay line.
module tb_dff_delay_line;
   import dff_pkg::*;

   localparam int unsigned W  = 8;
   localparam int unsigned S8 = clog2(8);
   localparam int unsigned S6 = clog2(6);
   localparam logic [7:0]  RV = 8'hA5;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_pass   = 0;

   // Every accepted beat {valid,data} since the last flush, oldest first.
   logic [8:0] hist[$];

   always #5 clk = ~clk;

   dff_delay_line_if #(.WIDTH(W), .SEL_W(S8)) bus8 ();
   dff_delay_line_if #(.WIDTH(W), .SEL_W(S6)) bus6 ();

   dff_delay_line #(.WIDTH(W), .DEPTH(8), .RESET_VAL(RV)) u_dut8 (
      .clk(clk), .reset(reset), .bus(bus8));
   dff_delay_line #(.WIDTH(W), .DEPTH(6), .RESET_VAL(RV)) u_dut6 (
      .clk(clk), .reset(reset), .bus(bus6));

   // Item visible at delay L is the one accepted L shifts ago.
   function automatic logic [8:0] exp_tap(input int depth, input int sel);
      int l;
      l = sel + 1;
      if (l > depth) l = depth;
      if (hist.size() >= l) return hist[hist.size() - l];
      return {1'b0, RV};
   endfunction

   function automatic logic exp_busy(input int depth);
      for (int i = 0; i < depth; i++)
         if (i < hist.size() && hist[hist.size() - 1 - i][8]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drive(input logic en, input logic clr, input logic vin, input logic [7:0] d);
      bus8.en = en;  bus8.clear = clr;  bus8.valid_in = vin;  bus8.d = d;
      bus6.en = en;  bus6.clear = clr;  bus6.valid_in = vin;  bus6.d = d;
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset || bus8.clear) hist.delete();
      else if (bus8.en)        hist.push_back({bus8.valid_in, bus8.d});
      if (hist.size() > 16) void'(hist.pop_front());
      #1;
   endtask

   task automatic test_reset();
      logic [8:0] e;
      drive(1'b1, 1'b0, 1'b1, 8'hFF);
      reset = 1'b1;
      tick();
      tick();
      n_checks++;
      if (bus8.q !== RV) $display("FAIL reset_q: got %h expected %h", bus8.q, RV);
      else n_pass++;
      n_checks++;
      if (bus8.valid_out !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus8.valid_out);
      else n_pass++;
      n_checks++;
      if ({bus8.busy, bus6.busy} !== 2'b00)
         $display("FAIL reset_busy: got %b%b expected 00", bus8.busy, bus6.busy);
      else n_pass++;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 1'b1, 8'($urandom));
         tick();
      end
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      bus8.delay_sel = 3'd2;
      #2 reset = 1'b1;
      #2 reset = 1'b0;
      tick();
      e = exp_tap(8, 2);
      n_checks++;
      if ({bus8.valid_out, bus8.q} !== e || bus8.valid_out !== 1'b1 || bus8.busy !== 1'b1)
         $display("FAIL reset_glitch: got %b/%h busy %b expected %h busy 1",
                  bus8.valid_out, bus8.q, bus8.busy, e);
      else n_pass++;
   endtask

   task automatic test_sel0();
      logic [7:0] vals [3];
      vals[0] = 8'h01;  vals[1] = 8'h02;  vals[2] = 8'h03;
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      tick();
      bus8.delay_sel = 3'd0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 1'b1, vals[i]);
         tick();
         n_checks++;
         if (bus8.q !== vals[i] || bus8.valid_out !== 1'b1)
            $display("FAIL sel0_stream[%0d]: got %b/%h expected 1/%h",
                     i, bus8.valid_out, bus8.q, vals[i]);
         else n_pass++;
      end
      for (int k = 1; k <= 8; k++) begin
         drive(1'b1, 1'b0, 1'b0, 8'($urandom));
         tick();
         n_checks++;
         if (bus8.busy !== (k < 8) || bus8.busy !== exp_busy(8))
            $display("FAIL sel0_busy[%0d]: got %b expected %b", k, bus8.busy, (k < 8));
         else n_pass++;
      end
   endtask

   task automatic test_sel3();
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      tick();
      bus8.delay_sel = 3'd3;
      drive(1'b1, 1'b0, 1'b1, 8'h3C);
      tick();
      for (int c = 2; c <= 8; c++) begin
         if (c == 5) begin
            bus8.delay_sel = 3'd7;
            #1;
            n_checks++;
            if (bus8.valid_out !== 1'b0)
               $display("FAIL sel3_switch: got valid %b expected 0", bus8.valid_out);
            else n_pass++;
         end
         drive(1'b1, 1'b0, 1'b0, 8'($urandom));
         tick();
         n_checks++;
         if (bus8.valid_out !== (c == 4 || c == 8) ||
             ((c == 4 || c == 8) && bus8.q !== 8'h3C) ||
             {bus8.valid_out, bus8.q} !== exp_tap(8, int'(bus8.delay_sel)))
            $display("FAIL sel3_tap[%0d]: got %b/%h expected valid %b data 3c",
                     c, bus8.valid_out, bus8.q, (c == 4 || c == 8));
         else n_pass++;
      end
   endtask

   task automatic test_stall();
      logic [7:0] got[$];
      logic [8:0] frozen;
      int         step;
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      tick();
      bus8.delay_sel = 3'd3;
      step = 0;
      for (int c = 0; c < 14; c++) begin
         if (c == 2 || c == 3 || c == 4) begin
            drive(1'b0, 1'b0, 1'($urandom), 8'($urandom));
            frozen = (c == 2) ? {bus8.valid_out, bus8.q} : frozen;
            tick();
            n_checks++;
            if ({bus8.valid_out, bus8.q} !== frozen)
               $display("FAIL stall_frozen[%0d]: got %b/%h expected %h",
                        c, bus8.valid_out, bus8.q, frozen);
            else n_pass++;
         end else begin
            if (step < 3) drive(1'b1, 1'b0, 1'b1, 8'h10 + 8'(step));
            else          drive(1'b1, 1'b0, 1'b0, 8'($urandom));
            step++;
            tick();
            if (bus8.valid_out) got.push_back(bus8.q);
            n_checks++;
            if ({bus8.valid_out, bus8.q} !== exp_tap(8, 3))
               $display("FAIL stall_tap[%0d]: got %b/%h expected %h",
                        c, bus8.valid_out, bus8.q, exp_tap(8, 3));
            else n_pass++;
         end
      end
      n_checks++;
      if (got.size() != 3 || got[0] !== 8'h10 || got[1] !== 8'h11 || got[2] !== 8'h12)
         $display("FAIL stall_sequence: got %0d items %p expected 10 11 12", got.size(), got);
      else n_pass++;
   endtask

   task automatic test_clear();
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      tick();
      bus8.delay_sel = 3'($urandom_range(0, 4));
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 1'b1, 8'($urandom_range(0, 127)));
         tick();
      end
      drive(1'b1, 1'b1, 1'b1, 8'hEE);
      tick();
      n_checks++;
      if (bus8.valid_out !== 1'b0 || bus8.q !== RV || bus8.busy !== 1'b0 || bus6.busy !== 1'b0)
         $display("FAIL clear_flush: got %b/%h busy %b%b expected 0/a5 busy 00",
                  bus8.valid_out, bus8.q, bus8.busy, bus6.busy);
      else n_pass++;
      for (int c = 0; c < 10; c++) begin
         bus8.delay_sel = 3'($urandom);
         drive(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 127)));
         tick();
         n_checks++;
         if (bus8.valid_out !== 1'b0 || bus8.q === 8'hEE)
            $display("FAIL clear_dropped[%0d]: got %b/%h expected invalid, never ee",
                     c, bus8.valid_out, bus8.q);
         else n_pass++;
      end
   endtask

   task automatic test_random_clamp();
      logic [8:0] e8;
      logic [8:0] e6;
      for (int c = 0; c < 300; c++) begin
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 40) == 0),
               1'($urandom), 8'($urandom));
         tick();
         bus8.delay_sel = 3'($urandom);
         bus6.delay_sel = 3'($urandom_range(5, 7));
         #1;
         e8 = exp_tap(8, int'(bus8.delay_sel));
         e6 = exp_tap(6, int'(bus6.delay_sel));
         n_checks++;
         if ({bus8.valid_out, bus8.q} !== e8 || bus8.busy !== exp_busy(8))
            $display("FAIL rand8[%0d]: got %b/%h busy %b expected %h busy %b",
                     c, bus8.valid_out, bus8.q, bus8.busy, e8, exp_busy(8));
         else n_pass++;
         n_checks++;
         if ($isunknown({bus6.valid_out, bus6.q}) || {bus6.valid_out, bus6.q} !== e6 ||
             bus6.busy !== exp_busy(6))
            $display("FAIL clamp6[%0d] sel %0d: got %b/%h busy %b expected %h busy %b",
                     c, bus6.delay_sel, bus6.valid_out, bus6.q, bus6.busy, e6, exp_busy(6));
         else n_pass++;
      end
   endtask

   initial begin
      reset          = 1'b1;
      bus8.delay_sel = '0;
      bus6.delay_sel = 3'd7;
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      test_reset();
      test_sel0();
      test_sel3();
      test_stall();
      test_clear();
      test_random_clamp();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
